fault_event_logger: RTL and testbench

FAULT_EVENT_LOGGER -- requirements
Module: fault_event_logger

---
 rtl/fault_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 48 ++++
 rtl/fault_event_logger.sv | 76 +++++++
 tb/tb_fault_event_logger.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared fault FSM encodings and event record field widths.
// Used by the fault FSM and the fault event logger.
package fault_pkg;

  localparam int STATE_W = 2;
  localparam int ID_W    = 3;
  localparam int META_W  = 2 * STATE_W + ID_W;

  typedef enum logic [STATE_W-1:0] {
    S_NORMAL   = 2'b00,
    S_WARNING  = 2'b01,
    S_FAULT    = 2'b10,
    S_SHUTDOWN = 2'b11
  } fault_state_e;

  localparam logic [ID_W-1:0] FID_NONE = 3'd0;
  localparam logic [ID_W-1:0] FID_UV   = 3'd1;
  localparam logic [ID_W-1:0] FID_OV   = 3'd2;
  localparam logic [ID_W-1:0] FID_OT   = 3'd3;
  localparam logic [ID_W-1:0] FID_UC   = 3'd4;

  typedef struct packed {
    logic [STATE_W-1:0] prev_state;
    logic [STATE_W-1:0] new_state;
    logic [ID_W-1:0]    fault_id;
  } ev_meta_t;

  function automatic ev_meta_t make_meta(
    input logic [STATE_W-1:0] prev_s,
    input logic [STATE_W-1:0] new_s,
    input logic [ID_W-1:0]    fid
  );
    ev_meta_t m;
    m.prev_state = prev_s;
    m.new_state  = new_s;
    m.fault_id   = fid;
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy level.
// A write while full is accepted only if the head pops on that edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_valid = (wr_ptr != rd_ptr);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  assign do_rd = rd_valid && rd_ready;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fault_event_logger.sv
// Timestamps fault FSM state/id changes into a FWFT event FIFO.
// Dropped events on a full FIFO are counted, saturating at 255.
module fault_event_logger
  import fault_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [STATE_W-1:0]      state_in,
  input  logic [ID_W-1:0]         fault_id_in,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [TS_W+META_W-1:0]  ev_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              overflow_cnt,
  input  logic                    clear_overflow
);

  logic [TS_W-1:0]    ts;
  logic [STATE_W-1:0] state_q;
  logic [ID_W-1:0]    id_q;
  logic               ev_det;
  logic               full;
  logic               pop;
  logic               drop;
  ev_meta_t           meta;

  assign ev_det = enable &&
                  ((state_in != state_q) ||
                   (fault_id_in != id_q));
  assign meta   = make_meta(state_q, state_in, fault_id_in);
  assign pop    = ev_valid && ev_ready;
  assign drop   = ev_det && full && !pop;

  // Inputs are tracked even while disabled so re-enable sees no stale edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts      <= '0;
      state_q <= S_NORMAL;
      id_q    <= FID_NONE;
    end else begin
      ts      <= ts + 1'b1;
      state_q <= state_in;
      id_q    <= fault_id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (clear_overflow) begin
      overflow_cnt <= {7'd0, drop};
    end else if (drop && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (TS_W + META_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (ev_det),
    .wr_data  ({ts, meta}),
    .full     (full),
    .rd_valid (ev_valid),
    .rd_ready (ev_ready),
    .rd_data  (ev_data),
    .level    (level)
  );

endmodule

// File: tb/tb_fault_event_logger.sv
// Bench for fault_event_logger: queue model plus directed scenarios.
// A second instance with TS_W=4 shares the stimulus to exercise ts wrap.
module tb_fault_event_logger;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  state_in;
  logic [2:0]  fault_id_in;
  logic        ev_ready;
  logic        clear_overflow;

  logic        ev_valid;
  logic [22:0] ev_data;
  logic [3:0]  level;
  logic [7:0]  overflow_cnt;

  logic        ev_valid4;
  logic [10:0] ev_data4;
  logic [3:0]  level4;
  logic [7:0]  overflow_cnt4;

  int checks = 0;
  int errors = 0;

  fault_event_logger #(.DEPTH(8), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .state_in(state_in), .fault_id_in(fault_id_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .level(level),
    .overflow_cnt(overflow_cnt),
    .clear_overflow(clear_overflow)
  );

  fault_event_logger #(.DEPTH(8), .TS_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .state_in(state_in), .fault_id_in(fault_id_in),
    .ev_valid(ev_valid4), .ev_ready(ev_ready),
    .ev_data(ev_data4), .level(level4),
    .overflow_cnt(overflow_cnt4),
    .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: event log as a queue of records with an unbounded cycle count
  typedef struct {
    int         ts;
    logic [1:0] ps;
    logic [1:0] ns;
    logic [2:0] id;
  } rec_t;

  rec_t       q[$];
  int         m_ts;
  logic [1:0] m_ps;
  logic [2:0] m_id;
  int         m_ovf;
  bit         m_on = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ts  = 0;
      m_ps  = 2'b00;
      m_id  = 3'd0;
      m_ovf = 0;
      m_on  = 1;
    end else if (m_on) begin
      bit   pop, ev, drop;
      rec_t r;
      pop  = (q.size() > 0) && ev_ready;
      ev   = enable && ((state_in != m_ps) || (fault_id_in != m_id));
      drop = ev && (q.size() == 8) && !pop;
      r.ts = m_ts;
      r.ps = m_ps;
      r.ns = state_in;
      r.id = fault_id_in;
      if (pop) void'(q.pop_front());
      if (ev && !drop) q.push_back(r);
      if (clear_overflow) m_ovf = drop ? 1 : 0;
      else if (drop && m_ovf < 255) m_ovf++;
      m_ps = state_in;
      m_id = fault_id_in;
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      logic [15:0] t16;
      logic [3:0]  t4;
      chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
      chk("ev_valid4", 32'(ev_valid4), 32'(q.size() > 0));
      if (q.size() > 0) begin
        t16 = 16'(q[0].ts);
        t4  = 4'(q[0].ts);
        chk("ev_data", 32'(ev_data),
            32'({t16, q[0].ps, q[0].ns, q[0].id}));
        chk("ev_data4", 32'(ev_data4),
            32'({t4, q[0].ps, q[0].ns, q[0].id}));
      end
    end
  end

  logic [1:0] tr_s [10];
  logic [2:0] tr_i [10];

  initial begin
    tr_s = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10,
             2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    tr_i = '{3'd2, 3'd3, 3'd0, 3'd4, 3'd1,
             3'd2, 3'd3, 3'd0, 3'd4, 3'd1};

    rst_n          = 1'b0;
    enable         = 1'b1;
    state_in       = 2'b00;
    fault_id_in    = 3'd0;
    ev_ready       = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ev_valid", 32'(ev_valid), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst ovf", 32'(overflow_cnt), 32'd0);
    rst_n = 1'b1;

    // single event at ts=5, consumed immediately
    repeat (5) @(negedge clk);
    ev_ready    = 1'b1;
    state_in    = 2'b01;
    fault_id_in = 3'd1;
    @(negedge clk);
    chk("first rec", 32'(ev_data),
        32'({16'd5, 2'b00, 2'b01, 3'd1}));
    chk("first valid", 32'(ev_valid), 32'd1);
    @(negedge clk);
    chk("valid one cycle", 32'(ev_valid), 32'd0);

    // ten transitions with no consumer: 8 kept, 2 dropped
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      state_in    = tr_s[i];
      fault_id_in = tr_i[i];
      @(negedge clk);
    end
    chk("fill level", 32'(level), 32'd8);
    chk("fill ovf", 32'(overflow_cnt), 32'd2);
    chk("fill head", 32'(ev_data[6:0]), 32'(7'b01_10_010));
    ev_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain level", 32'(level), 32'd0);

    // full FIFO: push+pop together, then drop with clear
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      state_in    = tr_s[i];
      fault_id_in = tr_i[i];
      @(negedge clk);
    end
    chk("full level", 32'(level), 32'd8);
    ev_ready    = 1'b1;
    state_in    = tr_s[8];
    fault_id_in = tr_i[8];
    @(negedge clk);
    chk("push+pop level", 32'(level), 32'd8);
    chk("push+pop ovf", 32'(overflow_cnt), 32'd2);
    ev_ready       = 1'b0;
    state_in       = tr_s[9];
    fault_id_in    = tr_i[9];
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("clear+drop ovf", 32'(overflow_cnt), 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("clear ovf", 32'(overflow_cnt), 32'd0);

    // saturation of the drop counter
    for (int i = 0; i < 260; i++) begin
      state_in = state_in + 2'd1;
      @(negedge clk);
    end
    chk("sat ovf", 32'(overflow_cnt), 32'd255);
    ev_ready = 1'b1;
    repeat (9) @(negedge clk);
    chk("drain2 level", 32'(level), 32'd0);

    // disabled changes leave no trace; next change logs prev=10
    enable   = 1'b0;
    state_in = 2'b00;
    @(negedge clk);
    state_in = 2'b01;
    @(negedge clk);
    state_in = 2'b10;
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("reenable level", 32'(level), 32'd0);
    ev_ready    = 1'b0;
    state_in    = 2'b11;
    fault_id_in = 3'd3;
    @(negedge clk);
    chk("reenable rec", 32'(ev_data[6:0]), 32'(7'b10_11_011));

    // reset with buffered events and a saturated counter
    state_in = 2'b00;
    @(negedge clk);
    state_in = 2'b10;
    @(negedge clk);
    chk("pre-rst level", 32'(level), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst level", 32'(level), 32'd0);
    chk("mid rst valid", 32'(ev_valid), 32'd0);
    chk("mid rst ovf", 32'(overflow_cnt), 32'd0);
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    chk("post-rst rec", 32'(ev_data),
        32'({16'd0, 2'b00, 2'b10, 3'd3}));

    // timestamp wrap on the 4-bit instance at ts=17
    repeat (16) @(negedge clk);
    state_in    = 2'b11;
    fault_id_in = 3'd4;
    @(negedge clk);
    chk("ts17 wide", 32'(ev_data[22:7]), 32'd17);
    chk("ts17 wrap", 32'(ev_data4[10:7]), 32'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
